// File: rtl/contador_seq_if.sv
// Control/status bundle between the sequencing controller and the board-side
// counter datapath plus its SWI-driven request inputs.
interface contador_seq_if #(
  parameter int unsigned NBITS   = 4,
  parameter int unsigned NPASSES = 2
);
  localparam int unsigned PCW = $clog2(NPASSES + 1);

  logic             start;
  logic             dir;
  logic             pause;
  logic             abort;
  logic [NBITS-1:0] load_val;
  logic [NBITS-1:0] limit;
  logic [NBITS-1:0] cnt_val;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_up;
  logic             busy;
  logic             done;
  logic [PCW-1:0]   pass_cnt;
  logic [2:0]       state_o;

  modport master (
    output start, dir, pause, abort, load_val, limit, cnt_val,
    input  cnt_load, cnt_en, cnt_up, busy, done, pass_cnt, state_o
  );

  modport slave (
    input  start, dir, pause, abort, load_val, limit, cnt_val,
    output cnt_load, cnt_en, cnt_up, busy, done, pass_cnt, state_o
  );
endinterface

// File: rtl/contador_seq.sv
// Sequencing controller: turns a start edge into prescaled load/step/reload
// passes over an external up/down counter, with pause, abort and done pulse.
module contador_seq #(
  parameter int unsigned NBITS    = 4,
  parameter int unsigned STEP_DIV = 1,
  parameter int unsigned NPASSES  = 2
) (
  input  logic          clk_2,
  input  logic          reset,
  contador_seq_if.slave bus
);
  localparam int unsigned PSW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned PCW = $clog2(NPASSES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    PAUSED = 3'd3,
    WRAP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_dir;
  logic             r_start_d;
  logic [PSW-1:0]   r_presc;
  logic [PCW-1:0]   r_pass_cnt;

  logic             w_start_edge;
  logic             w_slot;
  logic             w_at_term;
  logic             w_last_pass;
  logic [NBITS-1:0] w_terminal;
  logic [PCW-1:0]   w_pass_inc;

  assign w_start_edge = bus.start & ~r_start_d;
  assign w_slot       = (r_presc == PSW'(STEP_DIV - 1));
  assign w_terminal   = r_dir ? bus.limit : '0;
  assign w_at_term    = (bus.cnt_val == w_terminal);
  assign w_pass_inc   = r_pass_cnt + PCW'(1);
  assign w_last_pass  = (w_pass_inc == PCW'(NPASSES));

  // State register
  always_ff @(posedge clk_2) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; abort outranks pause, which outranks stepping
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_edge) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = bus.abort ? IDLE : RUN;
      RUN: begin
        if (bus.abort)                w_state_nxt = IDLE;
        else if (bus.pause)           w_state_nxt = PAUSED;
        else if (w_slot && w_at_term) w_state_nxt = WRAP;
      end
      PAUSED: begin
        if (bus.abort)       w_state_nxt = IDLE;
        else if (!bus.pause) w_state_nxt = RUN;
      end
      WRAP: begin
        if (bus.abort)        w_state_nxt = IDLE;
        else if (w_last_pass) w_state_nxt = DONE;
        else                  w_state_nxt = RUN;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Run context: direction, prescaler, pass count and start-edge history
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_dir      <= 1'b1;
      r_start_d  <= 1'b1;
      r_presc    <= '0;
      r_pass_cnt <= '0;
    end else begin
      r_start_d <= bus.start;
      case (r_state)
        IDLE: if (w_start_edge) begin
          r_dir      <= bus.dir;
          r_pass_cnt <= '0;
        end
        LOAD: if (!bus.abort) r_presc <= '0;
        RUN: if (!bus.abort && !bus.pause)
          r_presc <= w_slot ? '0 : r_presc + PSW'(1);
        WRAP: if (!bus.abort) begin
          r_pass_cnt <= w_pass_inc;
          r_presc    <= '0;
        end
        default: ;
      endcase
    end
  end

  // Datapath controls are combinational so abort/pause act in the same cycle
  always_comb begin
    bus.cnt_load = 1'b0;
    bus.cnt_en   = 1'b0;
    case (r_state)
      LOAD: bus.cnt_load = ~bus.abort;
      RUN:  bus.cnt_en   = ~bus.abort & ~bus.pause & w_slot & ~w_at_term;
      WRAP: bus.cnt_load = ~bus.abort & ~w_last_pass;
      default: ;
    endcase
  end

  assign bus.cnt_up   = r_dir;
  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = (r_state == DONE);
  assign bus.state_o  = r_state;
  assign bus.pass_cnt = r_pass_cnt;
endmodule

// File: tb/tb_contador_seq.sv
// Directed bench: two controller instances, each driving a small counter
// model, checked cycle by cycle against hand-computed sequences.
module tb_contador_seq;
  logic clk_2 = 1'b0;
  logic reset = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_done_a = 0;
  int   n_done_b = 0;
  int   n_load_b;
  logic [3:0] cnt_a, cnt_b;

  // Down two-pass run (STEP_DIV=3), cycles 1..17 after the start edge
  int b_st [17] = '{1,2,2,2,2,2,2,4,2,2,2,2,2,2,4,5,0};
  int b_ld [17] = '{1,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,0};
  int b_en [17] = '{0,0,0,1,0,0,0,0,0,0,1,0,0,0,0,0,0};
  int b_val[17] = '{-1,1,1,1,0,0,0,0,1,1,1,0,0,0,0,0,0};

  contador_seq_if #(.NBITS(4), .NPASSES(1)) a_if ();
  contador_seq_if #(.NBITS(4), .NPASSES(2)) b_if ();

  contador_seq #(.NBITS(4), .STEP_DIV(1), .NPASSES(1)) u_a (
    .clk_2(clk_2), .reset(reset), .bus(a_if)
  );
  contador_seq #(.NBITS(4), .STEP_DIV(3), .NPASSES(2)) u_b (
    .clk_2(clk_2), .reset(reset), .bus(b_if)
  );

  always #5 clk_2 = ~clk_2;

  // Counter datapath models
  always @(posedge clk_2) begin
    if (reset) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_if.cnt_load)    cnt_a <= a_if.load_val;
      else if (a_if.cnt_en) cnt_a <= a_if.cnt_up ? cnt_a + 4'd1 : cnt_a - 4'd1;
      if (b_if.cnt_load)    cnt_b <= b_if.load_val;
      else if (b_if.cnt_en) cnt_b <= b_if.cnt_up ? cnt_b + 4'd1 : cnt_b - 4'd1;
    end
  end
  assign a_if.cnt_val = cnt_a;
  assign b_if.cnt_val = cnt_b;

  always @(negedge clk_2) begin
    if (a_if.done) n_done_a++;
    if (b_if.done) n_done_b++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_2);
    #1;
  endtask

  task automatic step_a(input string tag, input int st, input int ld, input int en, input int val);
    cyc();
    #1;
    check({tag, " state"}, 32'(a_if.state_o), 32'(st));
    check({tag, " load"},  32'(a_if.cnt_load), 32'(ld));
    check({tag, " en"},    32'(a_if.cnt_en), 32'(en));
    if (val >= 0) check({tag, " val"}, 32'(a_if.cnt_val), 32'(val));
  endtask

  task automatic step_b(input string tag, input int st, input int ld, input int en, input int val);
    cyc();
    #1;
    check({tag, " state"}, 32'(b_if.state_o), 32'(st));
    check({tag, " load"},  32'(b_if.cnt_load), 32'(ld));
    check({tag, " en"},    32'(b_if.cnt_en), 32'(en));
    if (val >= 0) check({tag, " val"}, 32'(b_if.cnt_val), 32'(val));
  endtask

  task automatic check_reset_b(input string tag);
    check({tag, " state"}, 32'(b_if.state_o), 32'd0);
    check({tag, " load"},  32'(b_if.cnt_load), 32'd0);
    check({tag, " en"},    32'(b_if.cnt_en), 32'd0);
    check({tag, " up"},    32'(b_if.cnt_up), 32'd1);
    check({tag, " busy"},  32'(b_if.busy), 32'd0);
    check({tag, " done"},  32'(b_if.done), 32'd0);
    check({tag, " pass"},  32'(b_if.pass_cnt), 32'd0);
  endtask

  initial begin
    a_if.start = 1'b0; a_if.dir = 1'b1; a_if.pause = 1'b0; a_if.abort = 1'b0;
    a_if.load_val = 4'd2; a_if.limit = 4'd4;
    b_if.start = 1'b0; b_if.dir = 1'b0; b_if.pause = 1'b0; b_if.abort = 1'b0;
    b_if.load_val = 4'd1; b_if.limit = 4'd9;

    repeat (2) cyc();
    #1;
    check_reset_b("rst b");
    check("rst a state", 32'(a_if.state_o), 32'd0);
    check("rst a up",    32'(a_if.cnt_up), 32'd1);

    // start held high across reset release must not launch a run
    a_if.start = 1'b1;
    cyc();
    reset = 1'b0;
    cyc(); cyc();
    #1;
    check("hyg state", 32'(a_if.state_o), 32'd0);
    check("hyg busy",  32'(a_if.busy), 32'd0);
    a_if.start = 1'b0;
    cyc();

    // Up run 2 -> 4, single pass
    a_if.start = 1'b1;
    step_a("up c1", 1, 1, 0, -1); a_if.start = 1'b0;
    step_a("up c2", 2, 0, 1, 2);
    step_a("up c3", 2, 0, 1, 3);
    step_a("up c4", 2, 0, 0, 4);
    step_a("up c5", 4, 0, 0, 4);
    step_a("up c6", 5, 0, 0, 4);
    check("up c6 done", 32'(a_if.done), 32'd1);
    check("up c6 pass", 32'(a_if.pass_cnt), 32'd1);
    step_a("up c7", 0, 0, 0, 4);
    check("up c7 done", 32'(a_if.done), 32'd0);
    check("up c7 pass", 32'(a_if.pass_cnt), 32'd1);
    a_if.start = 1'b1; a_if.load_val = 4'd14; a_if.limit = 4'd1;

    // Restart straight after DONE, wrapping through 15 -> 0
    step_a("wrap c1", 1, 1, 0, 4);
    check("wrap pass clr", 32'(a_if.pass_cnt), 32'd0);
    a_if.start = 1'b0;
    step_a("wrap c2", 2, 0, 1, 14);
    step_a("wrap c3", 2, 0, 1, 15);
    step_a("wrap c4", 2, 0, 1, 0);
    step_a("wrap c5", 2, 0, 0, 1);
    step_a("wrap c6", 4, 0, 0, 1);
    step_a("wrap c7", 5, 0, 0, 1);
    step_a("wrap c8", 0, 0, 0, 1);
    a_if.start = 1'b1; a_if.load_val = 4'd3; a_if.limit = 4'd3;

    // load_val equals terminal: WRAP on first slot without stepping
    step_a("eq c1", 1, 1, 0, -1); a_if.start = 1'b0;
    step_a("eq c2", 2, 0, 0, 3);
    step_a("eq c3", 4, 0, 0, 3);
    step_a("eq c4", 5, 0, 0, 3);
    step_a("eq c5", 0, 0, 0, 3);
    check("eq pass", 32'(a_if.pass_cnt), 32'd1);

    // Down two-pass run; a start pulse mid-run must be ignored
    n_load_b = 0;
    b_if.start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      step_b($sformatf("down c%0d", c), b_st[c-1], b_ld[c-1], b_en[c-1], b_val[c-1]);
      check($sformatf("down c%0d up", c), 32'(b_if.cnt_up), 32'd0);
      if (b_if.cnt_load) n_load_b++;
      if (c == 1 || c == 6) b_if.start = 1'b0;
      if (c == 5) b_if.start = 1'b1;
      if (c == 9)  check("down pass1", 32'(b_if.pass_cnt), 32'd1);
      if (c == 16) begin
        check("down done", 32'(b_if.done), 32'd1);
        check("down pass2", 32'(b_if.pass_cnt), 32'd2);
      end
    end
    check("down loads", 32'(n_load_b), 32'd2);

    // Pause five cycles mid-RUN, resume from held prescaler, then abort
    b_if.start = 1'b1;
    step_b("pz c1", 1, 1, 0, -1); b_if.start = 1'b0;
    step_b("pz c2", 2, 0, 0, 1);
    cyc();
    b_if.pause = 1'b1;
    #1;
    check("pz c3 state", 32'(b_if.state_o), 32'd2);
    check("pz c3 en",    32'(b_if.cnt_en), 32'd0);
    for (int c = 4; c <= 8; c++) begin
      step_b($sformatf("pz c%0d", c), 3, 0, 0, 1);
      check($sformatf("pz c%0d busy", c), 32'(b_if.busy), 32'd1);
    end
    b_if.pause = 1'b0;
    step_b("pz c9", 2, 0, 0, 1);
    step_b("pz c10", 2, 0, 1, 1);
    cyc();
    b_if.abort = 1'b1;
    #1;
    check("ab c11 state", 32'(b_if.state_o), 32'd2);
    check("ab c11 en",    32'(b_if.cnt_en), 32'd0);
    check("ab c11 val",   32'(b_if.cnt_val), 32'd0);
    step_b("ab c12", 0, 0, 0, 0);
    check("ab c12 busy", 32'(b_if.busy), 32'd0);
    check("ab c12 done", 32'(b_if.done), 32'd0);
    b_if.abort = 1'b0;
    step_b("ab c13", 0, 0, 0, 0);

    // Reset in the middle of a run returns everything to reset values
    b_if.start = 1'b1;
    step_b("mr c1", 1, 1, 0, -1); b_if.start = 1'b0;
    step_b("mr c2", 2, 0, 0, 1);
    reset = 1'b1;
    cyc();
    #1;
    check_reset_b("mr rst");
    reset = 1'b0;
    cyc();

    check("done cnt a", 32'(n_done_a), 32'd3);
    check("done cnt b", 32'(n_done_b), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
